// File: rtl/alu_unit_if.sv
// ---------------------------------------------------------------------------
// alu_unit_if
// Operand / result bundle between the register file and the ALU.
//   DATA1  : operand A (register-file OUT1)
//   DATA2  : operand B or shift amount (register-file OUT2)
//   SELECT : opcode
//   START  : operation request
//   RESULT : registered result (register-file IN)
//   ZERO   : RESULT == 0, registered with RESULT
//   BUSY   : operation in progress
//   DONE   : one-cycle completion pulse
//   WRITE  : register-file write enable, coincident with DONE
// master = requester (register file / sequencer), slave = ALU.
// ---------------------------------------------------------------------------
interface alu_unit_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] DATA1;
    logic [WIDTH-1:0] DATA2;
    logic [2:0]       SELECT;
    logic             START;
    logic [WIDTH-1:0] RESULT;
    logic             ZERO;
    logic             BUSY;
    logic             DONE;
    logic             WRITE;

    modport master (
        output DATA1, DATA2, SELECT, START,
        input  RESULT, ZERO, BUSY, DONE, WRITE
    );

    modport slave (
        input  DATA1, DATA2, SELECT, START,
        output RESULT, ZERO, BUSY, DONE, WRITE
    );
endinterface

// File: rtl/alu_unit.sv
// ---------------------------------------------------------------------------
// alu_unit
// Multi-cycle 8-bit ALU with an IDLE/EXEC/FIN sequencer.
//   CLOCK : single clock, rising edge
//   RESET : synchronous, active-high
//   bus   : alu_unit_if.slave (operands, opcode, START in; RESULT, ZERO,
//           BUSY, DONE, WRITE out)
// Opcodes: 000 FWD, 001 ADD, 010 AND, 011 OR, 100 MUL (shift-add, 8 cycles),
//          101 LSL, 110 SRA, 111 ROR (one bit position per EXEC cycle).
// Latency from the accepting edge t: logic ops t+1, MUL t+9, shifts t+1+k.
// ---------------------------------------------------------------------------
module alu_unit #(
    parameter int WIDTH = 8
) (
    input  logic       CLOCK,
    input  logic       RESET,
    alu_unit_if.slave  bus
);
    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_LSL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;
    localparam logic [2:0] OP_ROR = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        FIN  = 2'b10
    } state_t;

    state_t           state_reg;
    logic [2:0]       op_reg;
    logic [3:0]       cnt_reg;       // remaining EXEC iterations
    logic [WIDTH-1:0] acc_reg;       // working value / product accumulator
    logic [WIDTH-1:0] mcand_reg;     // multiplicand, shifted left each step
    logic [WIDTH-1:0] mplier_reg;    // multiplier, shifted right each step

    logic [WIDTH-1:0] result_reg;
    logic             zero_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             write_reg;

    logic [WIDTH-1:0] quick_next;    // single-cycle result from live operands
    logic [WIDTH-1:0] acc_next;      // one EXEC iteration applied to acc_reg

    always_comb begin
        quick_next = bus.DATA2;
        unique case (bus.SELECT)
            OP_ADD:  quick_next = bus.DATA1 + bus.DATA2;
            OP_AND:  quick_next = bus.DATA1 & bus.DATA2;
            OP_OR:   quick_next = bus.DATA1 | bus.DATA2;
            default: quick_next = bus.DATA2;
        endcase
    end

    always_comb begin
        acc_next = acc_reg;
        unique case (op_reg)
            OP_MUL:  acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
            OP_LSL:  acc_next = {acc_reg[WIDTH-2:0], 1'b0};
            OP_SRA:  acc_next = {acc_reg[WIDTH-1], acc_reg[WIDTH-1:1]};
            OP_ROR:  acc_next = {acc_reg[0], acc_reg[WIDTH-1:1]};
            default: acc_next = acc_reg;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_reg  <= IDLE;
            op_reg     <= OP_FWD;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            result_reg <= '0;
            zero_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            write_reg  <= 1'b0;
        end else begin
            done_reg  <= 1'b0;
            write_reg <= 1'b0;
            // BUSY trails the state by one edge so it also covers the
            // cycle in which DONE is presented.
            busy_reg  <= (state_reg != IDLE);

            unique case (state_reg)
                IDLE: begin
                    if (bus.START) begin
                        op_reg <= bus.SELECT;
                        unique case (bus.SELECT)
                            OP_MUL: begin
                                acc_reg    <= '0;
                                mcand_reg  <= bus.DATA1;
                                mplier_reg <= bus.DATA2;
                                cnt_reg    <= 4'd8;
                                state_reg  <= EXEC;
                            end
                            OP_LSL, OP_SRA, OP_ROR: begin
                                acc_reg <= bus.DATA1;
                                cnt_reg <= {1'b0, bus.DATA2[2:0]};
                                // A zero shift amount has nothing to iterate.
                                state_reg <= (bus.DATA2[2:0] == 3'd0) ? FIN : EXEC;
                            end
                            default: begin
                                acc_reg   <= quick_next;
                                state_reg <= FIN;
                            end
                        endcase
                    end
                end

                EXEC: begin
                    acc_reg    <= acc_next;
                    mcand_reg  <= {mcand_reg[WIDTH-2:0], 1'b0};
                    mplier_reg <= {1'b0, mplier_reg[WIDTH-1:1]};
                    cnt_reg    <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        state_reg <= FIN;
                    end
                end

                FIN: begin
                    // Only completed values ever reach RESULT.
                    result_reg <= acc_reg;
                    zero_reg   <= (acc_reg == '0);
                    done_reg   <= 1'b1;
                    write_reg  <= 1'b1;
                    state_reg  <= IDLE;
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.RESULT = result_reg;
    assign bus.ZERO   = zero_reg;
    assign bus.BUSY   = busy_reg;
    assign bus.DONE   = done_reg;
    assign bus.WRITE  = write_reg;

endmodule

// File: tb/tb_alu_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_unit
// Self-checking bench for alu_unit: directed scenarios plus randomized
// operations, each compared cycle by cycle against an arithmetic reference.
// ---------------------------------------------------------------------------
module tb_alu_unit;
    logic CLOCK = 1'b0;
    logic RESET = 1'b1;

    alu_unit_if #(.WIDTH(8)) bus();

    alu_unit #(.WIDTH(8)) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLOCK = ~CLOCK;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] last_result = 8'h00;
    logic       last_zero   = 1'b0;

    // Reference: result straight from the opcode definitions.
    function automatic logic [7:0] ref_alu(input logic [2:0] op,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
        logic signed [7:0] sa;
        logic [15:0]       wide;
        logic [15:0]       dbl;
        int                k;
        sa   = a;
        k    = int'(b % 8);
        wide = 16'(a) * 16'(b);
        dbl  = {a, a} >> k;
        case (op)
            3'd0:    return b;
            3'd1:    return 8'((int'(a) + int'(b)) % 256);
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return wide[7:0];
            3'd5:    return 8'(a << k);
            3'd6:    return 8'(sa >>> k);
            default: return dbl[7:0];
        endcase
    endfunction

    // Reference: cycles from the accepting edge to the DONE edge.
    function automatic int ref_lat(input logic [2:0] op, input logic [7:0] b);
        if (op == 3'd4) return 9;
        if (op >= 3'd5) return 1 + int'(b % 8);
        return 1;
    endfunction

    // Launch one operation and check every cycle until it has retired.
    // poke > 0 re-asserts START (with scrambled operands) so that it is
    // sampled at edge t+poke, while the operation is still in flight.
    task automatic do_op(input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input int poke, input string name);
        logic [7:0] exp_v;
        logic [7:0] exp_res;
        logic       exp_done, exp_busy, exp_zero;
        int         lat;
        exp_v = ref_alu(op, a, b);
        lat   = ref_lat(op, b);
        @(negedge CLOCK);
        bus.SELECT = op;
        bus.DATA1  = a;
        bus.DATA2  = b;
        bus.START  = 1'b1;
        @(posedge CLOCK);
        for (int n = 0; n <= lat + 1; n++) begin
            @(negedge CLOCK);
            bus.START  = (n + 1 == poke);
            bus.DATA1  = 8'($urandom);
            bus.DATA2  = 8'($urandom);
            bus.SELECT = 3'($urandom);
            if (n >= 1) begin
                if (n < lat) begin
                    exp_done = 1'b0; exp_busy = 1'b1;
                    exp_res  = last_result; exp_zero = last_zero;
                end else if (n == lat) begin
                    exp_done = 1'b1; exp_busy = 1'b1;
                    exp_res  = exp_v; exp_zero = (exp_v == 8'h00);
                end else begin
                    exp_done = 1'b0; exp_busy = 1'b0;
                    exp_res  = exp_v; exp_zero = (exp_v == 8'h00);
                end
                vectors++;
                if ({bus.DONE, bus.WRITE, bus.BUSY, bus.RESULT, bus.ZERO} !==
                    {exp_done, exp_done, exp_busy, exp_res, exp_zero}) begin
                    miscompares++;
                    $display("FAIL %s t+%0d: done=%b write=%b busy=%b result=%h zero=%b, want done=%b write=%b busy=%b result=%h zero=%b",
                             name, n, bus.DONE, bus.WRITE, bus.BUSY, bus.RESULT, bus.ZERO,
                             exp_done, exp_done, exp_busy, exp_res, exp_zero);
                end
            end
        end
        bus.START   = 1'b0;
        last_result = exp_v;
        last_zero   = (exp_v == 8'h00);
        $display("op %s sel=%0d a=%h b=%h -> result=%h latency=%0d", name, op, a, b, exp_v, lat);
    endtask

    // Reset clears everything and wins over a simultaneous START.
    task automatic test_reset();
        @(negedge CLOCK);
        RESET      = 1'b1;
        bus.START  = 1'b1;
        bus.SELECT = 3'd0;
        bus.DATA1  = 8'hA5;
        bus.DATA2  = 8'h3C;
        repeat (3) @(negedge CLOCK);
        vectors++;
        if ({bus.RESULT, bus.ZERO, bus.BUSY, bus.DONE, bus.WRITE} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_state: result=%h zero=%b busy=%b done=%b write=%b, want all 0",
                     bus.RESULT, bus.ZERO, bus.BUSY, bus.DONE, bus.WRITE);
        end
        RESET     = 1'b0;
        bus.START = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge CLOCK);
            vectors++;
            if ({bus.RESULT, bus.ZERO, bus.BUSY, bus.DONE, bus.WRITE} !== 12'h000) begin
                miscompares++;
                $display("FAIL reset_start_dropped cycle %0d: result=%h zero=%b busy=%b done=%b write=%b, want all 0",
                         n, bus.RESULT, bus.ZERO, bus.BUSY, bus.DONE, bus.WRITE);
            end
        end
        last_result = 8'h00;
        last_zero   = 1'b0;
        $display("op reset with START held -> outputs cleared");
    endtask

    task automatic test_add();
        do_op(3'd1, 8'h7F, 8'h01, 0, "add");
        do_op(3'd1, 8'hFF, 8'h01, 0, "add_wrap");
    endtask

    task automatic test_mul();
        do_op(3'd4, 8'h0D, 8'h0B, 3, "mul_ignore_start");
    endtask

    task automatic test_shifts();
        do_op(3'd6, 8'h80, 8'h03, 0, "sra");
        do_op(3'd7, 8'h01, 8'h01, 0, "ror");
        do_op(3'd5, 8'h5A, 8'h00, 0, "lsl_k0");
    endtask

    // MUL aborted by RESET at t+4: no DONE/WRITE, outputs cleared.
    task automatic test_reset_abort();
        do_op(3'd0, 8'h00, 8'h5A, 0, "fwd_preload");
        @(negedge CLOCK);
        bus.SELECT = 3'd4;
        bus.DATA1  = 8'h0D;
        bus.DATA2  = 8'h0B;
        bus.START  = 1'b1;
        @(posedge CLOCK);
        for (int n = 0; n <= 14; n++) begin
            @(negedge CLOCK);
            bus.START = 1'b0;
            RESET     = (n == 3);
            if (n == 4) begin
                vectors++;
                if ({bus.BUSY, bus.RESULT, bus.ZERO} !== 10'h000) begin
                    miscompares++;
                    $display("FAIL reset_abort_clear: busy=%b result=%h zero=%b, want busy=0 result=00 zero=0",
                             bus.BUSY, bus.RESULT, bus.ZERO);
                end
            end
            if (n >= 1) begin
                vectors++;
                if ({bus.DONE, bus.WRITE} !== 2'b00) begin
                    miscompares++;
                    $display("FAIL reset_abort_pulse t+%0d: done=%b write=%b, want 0 0",
                             n, bus.DONE, bus.WRITE);
                end
            end
        end
        RESET       = 1'b0;
        last_result = 8'h00;
        last_zero   = 1'b0;
        $display("op mul aborted by reset at t+4");
        do_op(3'd0, 8'h00, 8'h33, 0, "fwd_after_reset");
    endtask

    // FWD at t, OR at t+2: results at t+1 and t+3, two DONE pulses.
    task automatic test_back_to_back();
        int dones;
        dones = 0;
        @(negedge CLOCK);
        bus.SELECT = 3'd0;
        bus.DATA1  = 8'($urandom);
        bus.DATA2  = 8'h11;
        bus.START  = 1'b1;
        @(posedge CLOCK);
        for (int n = 0; n <= 4; n++) begin
            @(negedge CLOCK);
            bus.START = (n == 1);
            if (n == 1) begin
                bus.SELECT = 3'd3;
                bus.DATA1  = 8'h0F;
                bus.DATA2  = 8'hF0;
            end
            if (n >= 1) begin
                if (bus.DONE === 1'b1) dones++;
            end
            if (n == 1) begin
                vectors++;
                if ({bus.RESULT, bus.DONE, bus.WRITE} !== {8'h11, 2'b11}) begin
                    miscompares++;
                    $display("FAIL b2b_first: result=%h done=%b write=%b, want 11 1 1",
                             bus.RESULT, bus.DONE, bus.WRITE);
                end
            end
            if (n == 2) begin
                vectors++;
                if ({bus.RESULT, bus.DONE} !== {8'h11, 1'b0}) begin
                    miscompares++;
                    $display("FAIL b2b_gap: result=%h done=%b, want 11 0", bus.RESULT, bus.DONE);
                end
            end
            if (n == 3) begin
                vectors++;
                if ({bus.RESULT, bus.ZERO, bus.DONE, bus.WRITE} !== {8'hFF, 3'b011}) begin
                    miscompares++;
                    $display("FAIL b2b_second: result=%h zero=%b done=%b write=%b, want ff 0 1 1",
                             bus.RESULT, bus.ZERO, bus.DONE, bus.WRITE);
                end
            end
        end
        vectors++;
        if (dones !== 2) begin
            miscompares++;
            $display("FAIL b2b_pulses: got %0d DONE pulses, want 2", dones);
        end
        last_result = 8'hFF;
        last_zero   = 1'b0;
        $display("op back-to-back fwd 11 then or 0f|f0 -> 11, ff");
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [7:0] a, b;
        int         poke;
        for (int i = 0; i < 40; i++) begin
            op   = 3'($urandom);
            a    = 8'($urandom);
            b    = 8'($urandom);
            poke = ($urandom_range(0, 1) == 1) ? $urandom_range(1, ref_lat(op, b)) : 0;
            do_op(op, a, b, poke, "random");
        end
    endtask

    initial begin
        bus.START  = 1'b0;
        bus.SELECT = 3'd0;
        bus.DATA1  = 8'h00;
        bus.DATA2  = 8'h00;
        test_reset();
        test_add();
        test_mul();
        test_shifts();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
